ram_port_a_arbiter: RTL and testbench
=====================================

// Module: ram_port_a_arbiter
// PURPOSE
// - Shares write-capable port A of a ram_DxW_rrw_p1p1 instance between two requesters (req0, req1).
// - Uses a per-requester valid/ready handshake, round-robin arbitration and a 1-cycle read-response pipeline.
// - Sits between, for example, a CPU data bus and a debug/loader master and the RAM. Port B of the RAM is not touched.
// - Optionally zero-fills the whole RAM after reset before accepting requests.
// PARAMETERS
// - DEPTH       4096            number of RAM words; power of two
// - WIDTH       8               data width in bits
// - DEPTH_BITS  $clog2(DEPTH)   localparam, address width
// PORTS
// - clock           in   1           single clock; all logic is posedge clock
// - reset           in   1           synchronous, active-high reset
// - req0_valid      in   1           requester 0 presents an access
// - req0_ready      out  1           requester 0 access accepted this cycle
// - req0_wr         in   1           1 = write, 0 = read
// - req0_addr       in   DEPTH_BITS  word address
// - req0_wdata      in   WIDTH       write data
// - req0_rsp_valid  out  1           read data valid for requester 0
// - req0_rdata      out  WIDTH       read data; valid only while req0_rsp_valid is high
// - req1_*          same set as req0_* for requester 1
// - ram_address_a   out  DEPTH_BITS  to RAM address_a
// - ram_wren_a      out  1           to RAM wren_a
// - ram_data_a      out  WIDTH       to RAM data_a
// - ram_q_a         in   WIDTH       from RAM q_a (1-cycle registered read)
// - init_done       out  1           high once the arbiter accepts requests
// BEHAVIOUR
// - Reset values:
//   - reqN_ready = 0, reqN_rsp_valid = 0, ram_wren_a = 0, init_done = 0.
//   - Round-robin pointer last_grant = 1, so req0 wins the first conflict.
//   - Any pending read response is discarded.
// - FSM states INIT and RUN:
//   - Reset enters INIT if RAM_ARB_INIT_CLEAR_EN is defined, else RUN.
//   - INIT -> RUN after the last clear write; RUN is left only by reset.
// - Arbitration in RUN (combinational, same cycle):
//   - Only one valid -> that requester is granted.
//   - Both valid -> the one not equal to last_grant is granted.
//   - No valid -> no grant; ram_wren_a = 0.
//   - last_grant updates only on a grant.
// - Handshake:
//   - reqN_ready = (state==RUN) && grant==N. An access transfers when valid && ready.
//   - Requester inputs must stay stable while valid && !ready.
//   - Ready never depends on ready of the other requester.
// - RAM drive:
//   - On a transfer: ram_address_a = addr, ram_data_a = wdata, ram_wren_a = wr.
//   - Otherwise ram_wren_a = 0; address and data are don't-care.
// - Read latency: a read accepted in cycle T gives reqN_rsp_valid = 1 in cycle T+1, for exactly 1 cycle, with reqN_rdata = ram_q_a.
// - Writes produce no response.
// - Back-to-back reads from either requester are accepted every cycle, giving 1 access/cycle throughput.
// - Write then read of the same address in consecutive cycles returns the new data.
// - A reqN_rdata value is held only during its rsp_valid cycle; outside it the value is unspecified.
// - Reset mid-operation:
//   - A read accepted in the reset cycle gets no response.
//   - A write presented in the reset cycle is not performed (ram_wren_a forced to 0).
// CONFIGURATION
// - RAM_ARB_INIT_CLEAR_EN defined:
//   - In INIT a DEPTH_BITS counter starting at 0 drives ram_address_a = counter, ram_data_a = 0, ram_wren_a = 1, one word per cycle.
//   - After address DEPTH-1 is written, the next cycle is RUN with init_done = 1, i.e. DEPTH cycles after reset is released.
//   - reqN_ready = 0 throughout INIT. Reset during INIT restarts at address 0.
// - RAM_ARB_INIT_CLEAR_EN not defined:
//   - No INIT state. init_done goes 1 in the first cycle after reset is released.
//   - RAM contents are not modified.
// TESTING
// - T1 single read: req0 reads 0x010 (preloaded 0xA5); req0_ready=1 at T, req0_rsp_valid=1 with rdata=0xA5 at T+1, req1_rsp_valid stays 0.
// - T2 conflict: both valid for 4 cycles (req0 reads 0x001..0x002, req1 reads 0x101..0x102); grants alternate 0,1,0,1 and each response returns to the correct requester at T+1.
// - T3 write/read: req1 writes 0x3C to 0xFFF, next cycle reads 0xFFF; rdata=0x3C. req0 then reads 0xFFF and gets 0x3C.
// - T4 reset mid-read: req0 read accepted in the reset cycle; no rsp_valid afterwards; first conflict after reset is granted to req0.
// - T5 (RAM_ARB_INIT_CLEAR_EN) preload 0xFF everywhere, reset; init_done rises exactly 4096 cycles after reset falls; reads of 0x000, 0x7FF, 0xFFF return 0x00; req0_valid held during INIT sees ready=0.
// - T6 (RAM_ARB_INIT_CLEAR_EN) reset asserted at init address 0x800; clear restarts at 0x000 and init_done rises 4096 cycles after the second reset release.

Source files
------------

// File: rtl/ram_port_a_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_a_arbiter
//
// Shares the write-capable port A of a ram_DxW_rrw_p1p1 instance between two
// requesters. Each requester has a valid/ready handshake. Simultaneous
// requests are resolved round-robin. Reads return one cycle after
// acceptance. Port B of the RAM is not touched by this block.
//
// Optional feature (macro RAM_ARB_INIT_CLEAR_EN):
//   When the macro is defined, the arbiter zero-fills the whole RAM after
//   reset, writing one word per cycle. Requests are accepted only after the
//   fill is complete. In the default build (macro undefined), the arbiter
//   accepts requests right after reset and leaves the RAM contents untouched.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (0/1)
//   reqN_wr, reqN_addr, reqN_wdata
//                                access type (1 = write), word address and
//                                write data
//   reqN_rsp_valid, reqN_rdata   read response, one cycle after acceptance
//   ram_address_a, ram_wren_a, ram_data_a
//                                drive to the RAM port A
//   ram_q_a                      registered read data from the RAM port A
//   init_done                    high while the arbiter accepts requests
// ---------------------------------------------------------------------------
module ram_port_a_arbiter #(
  parameter  int DEPTH      = 4096,
  parameter  int WIDTH      = 8,
  localparam int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wr,
  input  logic [DEPTH_BITS-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_wdata,
  output logic                  req0_rsp_valid,
  output logic [WIDTH-1:0]      req0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wr,
  input  logic [DEPTH_BITS-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_wdata,
  output logic                  req1_rsp_valid,
  output logic [WIDTH-1:0]      req1_rdata,

  output logic [DEPTH_BITS-1:0] ram_address_a,
  output logic                  ram_wren_a,
  output logic [WIDTH-1:0]      ram_data_a,
  input  logic [WIDTH-1:0]      ram_q_a,

  output logic                  init_done
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

`ifdef RAM_ARB_INIT_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t state;
  state_t state_next;

  // The last_grant register holds the index of the requester that won most
  // recently. On a conflict, the other requester is favoured.
  logic last_grant;
  logic grant_valid;
  logic grant_sel;

  logic rsp0_pending;
  logic rsp1_pending;

`ifdef RAM_ARB_INIT_CLEAR_EN
  logic [DEPTH_BITS-1:0] clear_addr;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: INIT runs until the last word has been cleared.
  // RUN is left only through reset.
  always_comb begin
    state_next = state;
`ifdef RAM_ARB_INIT_CLEAR_EN
    if (state == INIT && clear_addr == DEPTH_BITS'(DEPTH - 1)) begin
      state_next = RUN;
    end
`endif
  end

`ifdef RAM_ARB_INIT_CLEAR_EN
  // The clear address restarts from zero on every reset, including a
  // reset that arrives partway through a fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_addr <= '0;
    end else if (state == INIT) begin
      clear_addr <= clear_addr + 1'b1;
    end
  end
`endif

  // Output logic: arbitration, handshake, and RAM drive.
  // Gating with !reset ensures that nothing transfers in a reset cycle.
  // In particular, a write presented during reset never reaches the RAM.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (state == RUN && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_sel   = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_sel   = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_sel   = 1'b1;
      end
    end

    req0_ready    = grant_valid && !grant_sel;
    req1_ready    = grant_valid && grant_sel;
    ram_address_a = grant_sel ? req1_addr  : req0_addr;
    ram_data_a    = grant_sel ? req1_wdata : req0_wdata;
    ram_wren_a    = grant_valid && (grant_sel ? req1_wr : req0_wr);
    init_done     = (state == RUN) && !reset;

`ifdef RAM_ARB_INIT_CLEAR_EN
    if (state == INIT) begin
      ram_address_a = clear_addr;
      ram_data_a    = '0;
      ram_wren_a    = !reset;
    end
`endif
  end

  // Round-robin pointer and read-response pipeline. The RAM registers its
  // read data, so the response pulse is the accepted read delayed by one
  // cycle. Reset discards any pending response.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant   <= 1'b1;
      rsp0_pending <= 1'b0;
      rsp1_pending <= 1'b0;
    end else begin
      if (grant_valid) begin
        last_grant <= grant_sel;
      end
      rsp0_pending <= req0_ready && !req0_wr;
      rsp1_pending <= req1_ready && !req1_wr;
    end
  end

  assign req0_rsp_valid = rsp0_pending;
  assign req1_rsp_valid = rsp1_pending;
  assign req0_rdata     = ram_q_a;
  assign req1_rdata     = ram_q_a;

endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_a_arbiter
//
// Directed testbench for ram_port_a_arbiter. A behavioural single-port RAM
// with a one-cycle registered read sits behind the arbiter. The bench has a
// side port that preloads or fills the RAM contents.
//
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge of the same cycle. With RAM_ARB_INIT_CLEAR_EN defined,
// the bench also covers the zero-fill sequence.
// ---------------------------------------------------------------------------
module tb_ram_port_a_arbiter;

  localparam int DEPTH      = 4096;
  localparam int WIDTH      = 8;
  localparam int DEPTH_BITS = 12;

  logic                  clock;
  logic                  reset;
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_wr;
  logic [DEPTH_BITS-1:0] req0_addr;
  logic [WIDTH-1:0]      req0_wdata;
  logic                  req0_rsp_valid;
  logic [WIDTH-1:0]      req0_rdata;
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_wr;
  logic [DEPTH_BITS-1:0] req1_addr;
  logic [WIDTH-1:0]      req1_wdata;
  logic                  req1_rsp_valid;
  logic [WIDTH-1:0]      req1_rdata;
  logic [DEPTH_BITS-1:0] ram_address_a;
  logic                  ram_wren_a;
  logic [WIDTH-1:0]      ram_data_a;
  logic [WIDTH-1:0]      ram_q_a;
  logic                  init_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0]      mem [0:DEPTH-1];
  logic                  tb_wr_en;
  logic [DEPTH_BITS-1:0] tb_wr_addr;
  logic [WIDTH-1:0]      tb_wr_data;
  logic                  tb_fill_en;
  logic [WIDTH-1:0]      tb_fill_data;

  ram_port_a_arbiter #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_wr        (req0_wr),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_rsp_valid (req0_rsp_valid),
    .req0_rdata     (req0_rdata),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_wr        (req1_wr),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_rsp_valid (req1_rsp_valid),
    .req1_rdata     (req1_rdata),
    .ram_address_a  (ram_address_a),
    .ram_wren_a     (ram_wren_a),
    .ram_data_a     (ram_data_a),
    .ram_q_a        (ram_q_a),
    .init_done      (init_done)
  );

  always #5 clock = ~clock;

  // Behavioural RAM port A: write on the edge, registered read of the
  // old contents. Bench fill and preload take priority over the DUT.
  always @(posedge clock) begin
    if (tb_fill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= tb_fill_data;
      end
    end else if (tb_wr_en) begin
      mem[tb_wr_addr] <= tb_wr_data;
    end else if (ram_wren_a) begin
      mem[ram_address_a] <= ram_data_a;
    end
    ram_q_a <= mem[ram_address_a];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive the inputs just after the edge, then wait until the
  // falling edge so that the caller can sample the outputs.
  task automatic apply_stimulus(input logic rst,
                                input logic v0, input logic wr0,
                                input logic [DEPTH_BITS-1:0] a0,
                                input logic [WIDTH-1:0] d0,
                                input logic v1, input logic wr1,
                                input logic [DEPTH_BITS-1:0] a1,
                                input logic [WIDTH-1:0] d1);
    @(posedge clock);
    #1;
    reset      = rst;
    req0_valid = v0;
    req0_wr    = wr0;
    req0_addr  = a0;
    req0_wdata = d0;
    req1_valid = v1;
    req1_wr    = wr1;
    req1_addr  = a1;
    req1_wdata = d1;
    @(negedge clock);
  endtask

  task automatic idle_cycle(input logic rst);
    apply_stimulus(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tb_write(input logic [DEPTH_BITS-1:0] addr,
                          input logic [WIDTH-1:0] data);
    @(posedge clock);
    #1;
    tb_wr_en   = 1'b1;
    tb_wr_addr = addr;
    tb_wr_data = data;
    @(posedge clock);
    #1;
    tb_wr_en   = 1'b0;
  endtask

  task automatic tb_fill(input logic [WIDTH-1:0] data);
    @(posedge clock);
    #1;
    tb_fill_en   = 1'b1;
    tb_fill_data = data;
    @(posedge clock);
    #1;
    tb_fill_en   = 1'b0;
  endtask

  task automatic preload;
    tb_write(12'h010, 8'hA5);
    tb_write(12'h001, 8'h11);
    tb_write(12'h002, 8'h12);
    tb_write(12'h101, 8'h21);
    tb_write(12'h102, 8'h22);
  endtask

  // Counts cycles, starting with the current one, until init_done is seen.
  // Inputs are held, and any ready seen during the wait is noted.
  task automatic wait_init(output int n, output logic saw_ready);
    n         = 0;
    saw_ready = 1'b0;
    while (!init_done && n < 6000) begin
      if (req0_ready || req1_ready) saw_ready = 1'b1;
      n++;
      @(posedge clock);
      #1;
      @(negedge clock);
    end
  endtask

  initial begin
    int   n;
    logic saw;
    clock        = 1'b0;
    reset        = 1'b1;
    req0_valid   = 1'b0;
    req0_wr      = 1'b0;
    req0_addr    = '0;
    req0_wdata   = '0;
    req1_valid   = 1'b0;
    req1_wr      = 1'b0;
    req1_addr    = '0;
    req1_wdata   = '0;
    tb_wr_en     = 1'b0;
    tb_wr_addr   = '0;
    tb_wr_data   = '0;
    tb_fill_en   = 1'b0;
    tb_fill_data = '0;

    idle_cycle(1'b1);
`ifdef RAM_ARB_INIT_CLEAR_EN
    tb_fill(8'hFF);
`else
    tb_fill(8'h00);
`endif
    preload();

    // A request held during reset must not be accepted
    apply_stimulus(1'b1, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("rst_ready0", 32'(req0_ready), 32'd0);
    check_output("rst_wren", 32'(ram_wren_a), 32'd0);
    check_output("rst_init_done", 32'(init_done), 32'd0);
    check_output("rst_rsp0", 32'(req0_rsp_valid), 32'd0);

`ifdef RAM_ARB_INIT_CLEAR_EN
    // T5: zero-fill after reset while req0 holds a read of 0x000
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("t5_first_clear_addr", 32'(ram_address_a), 32'h000);
    check_output("t5_first_clear_wren", 32'(ram_wren_a), 32'd1);
    wait_init(n, saw);
    check_output("t5_init_cycles", 32'(n), 32'd4096);
    check_output("t5_ready_in_init", 32'(saw), 32'd0);
    check_output("t5_ready0_after_init", 32'(req0_ready), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h7FF, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("t5_rsp_000", 32'(req0_rsp_valid), 32'd1);
    check_output("t5_rdata_000", 32'(req0_rdata), 32'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("t5_rdata_7ff", 32'(req0_rdata), 32'h00);
    idle_cycle(1'b0);
    check_output("t5_rsp_fff", 32'(req0_rsp_valid), 32'd1);
    check_output("t5_rdata_fff", 32'(req0_rdata), 32'h00);

    // T6: reset partway through the fill restarts it from address 0
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    n = 0;
    while (!(ram_wren_a && ram_address_a == 12'h800) && n < 5000) begin
      idle_cycle(1'b0);
      n++;
    end
    check_output("t6_reach_800", 32'(ram_address_a), 32'h800);
    idle_cycle(1'b1);
    check_output("t6_rst_wren", 32'(ram_wren_a), 32'd0);
    idle_cycle(1'b0);
    check_output("t6_restart_addr", 32'(ram_address_a), 32'h000);
    check_output("t6_restart_wren", 32'(ram_wren_a), 32'd1);
    wait_init(n, saw);
    check_output("t6_init_cycles", 32'(n), 32'd4096);
    preload();
`else
    idle_cycle(1'b0);
    check_output("init_done_after_reset", 32'(init_done), 32'd1);
    check_output("no_rsp_after_reset", 32'(req0_rsp_valid), 32'd0);
`endif

    // T2: conflict, with grants alternating 0,1,0,1
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h001, 8'h00, 1'b1, 1'b0, 12'h101, 8'h00);
    check_output("t2_c1_ready0", 32'(req0_ready), 32'd1);
    check_output("t2_c1_ready1", 32'(req1_ready), 32'd0);
    check_output("t2_c1_addr", 32'(ram_address_a), 32'h001);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h002, 8'h00, 1'b1, 1'b0, 12'h101, 8'h00);
    check_output("t2_c2_ready0", 32'(req0_ready), 32'd0);
    check_output("t2_c2_ready1", 32'(req1_ready), 32'd1);
    check_output("t2_c2_addr", 32'(ram_address_a), 32'h101);
    check_output("t2_c2_rsp0", 32'(req0_rsp_valid), 32'd1);
    check_output("t2_c2_rdata0", 32'(req0_rdata), 32'h11);
    check_output("t2_c2_rsp1", 32'(req1_rsp_valid), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h002, 8'h00, 1'b1, 1'b0, 12'h102, 8'h00);
    check_output("t2_c3_ready0", 32'(req0_ready), 32'd1);
    check_output("t2_c3_addr", 32'(ram_address_a), 32'h002);
    check_output("t2_c3_rsp1", 32'(req1_rsp_valid), 32'd1);
    check_output("t2_c3_rdata1", 32'(req1_rdata), 32'h21);
    check_output("t2_c3_rsp0", 32'(req0_rsp_valid), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h102, 8'h00);
    check_output("t2_c4_ready1", 32'(req1_ready), 32'd1);
    check_output("t2_c4_addr", 32'(ram_address_a), 32'h102);
    check_output("t2_c4_rsp0", 32'(req0_rsp_valid), 32'd1);
    check_output("t2_c4_rdata0", 32'(req0_rdata), 32'h12);
    idle_cycle(1'b0);
    check_output("t2_c5_rsp1", 32'(req1_rsp_valid), 32'd1);
    check_output("t2_c5_rdata1", 32'(req1_rdata), 32'h22);
    check_output("t2_c5_rsp0", 32'(req0_rsp_valid), 32'd0);

    // T1: single read by req0
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("t1_ready0", 32'(req0_ready), 32'd1);
    check_output("t1_ready1", 32'(req1_ready), 32'd0);
    check_output("t1_addr", 32'(ram_address_a), 32'h010);
    check_output("t1_wren", 32'(ram_wren_a), 32'd0);
    idle_cycle(1'b0);
    check_output("t1_rsp0", 32'(req0_rsp_valid), 32'd1);
    check_output("t1_rdata0", 32'(req0_rdata), 32'hA5);
    check_output("t1_rsp1", 32'(req1_rsp_valid), 32'd0);
    idle_cycle(1'b0);
    check_output("t1_rsp0_single", 32'(req0_rsp_valid), 32'd0);

    // T3: write followed directly by a read of the same address
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'hFFF, 8'h3C);
    check_output("t3_wr_ready1", 32'(req1_ready), 32'd1);
    check_output("t3_wr_wren", 32'(ram_wren_a), 32'd1);
    check_output("t3_wr_addr", 32'(ram_address_a), 32'hFFF);
    check_output("t3_wr_data", 32'(ram_data_a), 32'h3C);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'hFFF, 8'h00);
    check_output("t3_rd_ready1", 32'(req1_ready), 32'd1);
    check_output("t3_rd_wren", 32'(ram_wren_a), 32'd0);
    check_output("t3_wr_no_rsp", 32'(req1_rsp_valid), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("t3_ready0", 32'(req0_ready), 32'd1);
    check_output("t3_rsp1", 32'(req1_rsp_valid), 32'd1);
    check_output("t3_rdata1", 32'(req1_rdata), 32'h3C);
    idle_cycle(1'b0);
    check_output("t3_rsp0", 32'(req0_rsp_valid), 32'd1);
    check_output("t3_rdata0", 32'(req0_rdata), 32'h3C);

    // T4: a read and a write presented during reset; then the first conflict
    // after reset goes to req0
    apply_stimulus(1'b1, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 1'b0, '0, '0);
    check_output("t4_rst_rd_wren", 32'(ram_wren_a), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h010, 8'h77);
    check_output("t4_rst_wr_wren", 32'(ram_wren_a), 32'd0);
    idle_cycle(1'b0);
    check_output("t4_no_rsp0", 32'(req0_rsp_valid), 32'd0);
    check_output("t4_no_rsp1", 32'(req1_rsp_valid), 32'd0);
`ifdef RAM_ARB_INIT_CLEAR_EN
    wait_init(n, saw);
    check_output("t4_init_cycles", 32'(n), 32'd4096);
    preload();
`endif
    apply_stimulus(1'b0, 1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 1'b0, 12'h101, 8'h00);
    check_output("t4_conflict_ready0", 32'(req0_ready), 32'd1);
    check_output("t4_conflict_ready1", 32'(req1_ready), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h101, 8'h00);
    check_output("t4_ready1", 32'(req1_ready), 32'd1);
    check_output("t4_rsp0", 32'(req0_rsp_valid), 32'd1);
    check_output("t4_rdata0_unwritten", 32'(req0_rdata), 32'hA5);
    idle_cycle(1'b0);
    check_output("t4_rsp1", 32'(req1_rsp_valid), 32'd1);
    check_output("t4_rdata1", 32'(req1_rdata), 32'h21);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
